// File: rtl/bank_ram.sv
// bank_ram: single-port word memory with per-byte write enables and a
// one-cycle registered response path (read-before-write on writes).
//
// Optional feature: define BANK_RAM_CLEAR_EN to zero every word after reset.
// In that build the block sits in CLEAR for DEPTH cycles (busy=1,
// req_ready=0) before it accepts requests. Without it the block is ready
// straight out of reset and memory keeps its contents across reset.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   request handshake (accepted when both are 1)
//   req_we            1 = write, 0 = read
//   req_adr           word address; >= DEPTH is out of range
//   req_wdata/be      write data and per-byte-lane enables
//   rsp_valid         one-cycle strobe, the cycle after acceptance
//   rsp_data          word contents before the request (0 if out of range)
//   rsp_err           out-of-range flag, qualified by rsp_valid
//   busy              clear sequence in progress
module bank_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_adr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH widened by one bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;

  logic              in_range;
  logic              accept;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

`ifdef BANK_RAM_CLEAR_EN
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_CLEAR);
`else
  assign req_ready = 1'b1;
  assign busy      = 1'b0;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Request decode, response next-state, memory write port and clear FSM
  always_comb begin
    in_range    = ({1'b0, req_adr} < DEPTH_X);
    req_idx     = IDX_W'(req_adr);
    rd_word     = in_range ? mem[req_idx] : '0;
    accept      = req_valid && req_ready && !rst;

    // Unselected lanes keep the old word so a single full-word write suffices
    for (int i = 0; i < int'(BE_W); i++) begin
      merged[8*i +: 8] = req_be[i] ? req_wdata[8*i +: 8] : rd_word[8*i +: 8];
    end

    rsp_valid_d = accept;
    rsp_data_d  = accept ? rd_word : '0;
    rsp_err_d   = accept && !in_range;

    mem_we      = accept && req_we && in_range;
    mem_idx     = req_idx;
    mem_wdata   = merged;

`ifdef BANK_RAM_CLEAR_EN
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    // No request is accepted in CLEAR, so the write port is free for zeroing
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_cnt_q;
      mem_wdata = '0;
      if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d   = S_IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
      end
    end
`endif
  end

  // Response and FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef BANK_RAM_CLEAR_EN
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef BANK_RAM_CLEAR_EN
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

  // Storage array; contents are deliberately not touched by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

endmodule

// File: doc/bank_ram.md
BANK_RAM -- requirements
Module: bank_ram

Interface
REQ-001 Parameter DATA_W, 64: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, 16: address width in bits.
REQ-003 Parameter DEPTH, 2**ADDR_W: number of implemented words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_adr  input  ADDR_W  word address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_be  input  DATA_W/8  byte enables; bit i selects byte lane i (bits 8i+7:8i).
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_data  output  DATA_W  response data.
REQ-014 rsp_err  output  1  address out of range; qualified by rsp_valid.
REQ-015 busy  output  1  clear sequence in progress.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 req_ready SHALL be 1 in state IDLE and 0 in state CLEAR, independent of req_valid.
REQ-018 Every accepted request SHALL produce exactly one rsp_valid pulse on the cycle after acceptance; throughput is one request per cycle, with no response backpressure.
REQ-019 Read: rsp_data SHALL equal mem[req_adr] as stored before the accepting edge.
REQ-020 Write: each lane with req_be[i]=1 SHALL be updated at the accepting edge; lanes with req_be[i]=0 SHALL be unchanged; rsp_data SHALL return the word contents before the write (read-before-write).
REQ-021 A write with req_be all zero SHALL leave memory unchanged and still produce a response.
REQ-022 A read accepted on the cycle after a write to the same address SHALL return the newly written data.
REQ-023 Out of range (req_adr >= DEPTH): a write SHALL have no effect, rsp_data SHALL be 0, and rsp_err SHALL be 1; reads SHALL behave the same way.
REQ-024 rsp_data and rsp_err SHALL be 0 whenever rsp_valid is 0.
REQ-025 State machine CLEAR/IDLE: CLEAR writes zero to word clr_cnt each cycle, with clr_cnt counting from 0; at clr_cnt = DEPTH-1 it SHALL go to IDLE on the next edge; CLEAR therefore lasts exactly DEPTH cycles.
REQ-026 busy SHALL be 1 exactly when the state is CLEAR.
REQ-027 req_valid asserted during CLEAR SHALL be ignored, with no response and no memory effect.

Reset
REQ-028 With rst=1 at an edge, the block SHALL set rsp_valid=0, rsp_data=0, rsp_err=0 and clr_cnt=0, and SHALL enter the post-reset state (see REQ-030/031).
REQ-029 Reset asserted mid-CLEAR SHALL restart the clear from word 0; a response pending at reset SHALL be discarded.

Configuration
REQ-030 With macro BANK_RAM_CLEAR_EN defined: the post-reset state SHALL be CLEAR, so req_ready=0 and busy=1 for DEPTH cycles after rst deasserts, and all words read 0 afterwards.
REQ-031 Without BANK_RAM_CLEAR_EN: the post-reset state SHALL be IDLE, req_ready=1 on the first cycle after reset, busy SHALL be constant 0, memory contents SHALL NOT be altered by reset, and no clear counter logic SHALL be built.

Verification (DATA_W=64, ADDR_W=4, DEPTH=12, BANK_RAM_CLEAR_EN defined unless noted)
REQ-032 rst high for 1 cycle -> busy=1 and req_ready=0 for 12 cycles, then req_ready=1; read adr 11 -> rsp_data=0, rsp_err=0.
REQ-033 Write adr 3, wdata 0x1122334455667788, be 0xFF, then read adr 3 on the next cycle -> write response rsp_data=0; read response rsp_data=0x1122334455667788.
REQ-034 Then write adr 3, wdata 0xAAAAAAAAAAAAAAAA, be 0x0F, then read adr 3 -> read response 0x11223344AAAAAAAA.
REQ-035 Write adr 13, then read adr 13 -> both responses have rsp_err=1 and rsp_data=0; read adr 3 is unchanged.
REQ-036 rst asserted at clear cycle 5 -> clear restarts and req_ready rises 12 cycles after rst falls; requests issued during CLEAR get no rsp_valid.
REQ-037 Without BANK_RAM_CLEAR_EN, rst pulse -> req_ready=1 on the next cycle; data written before reset reads back unchanged.
